// File: rtl/sha256_axilite_regif.sv
`default_nettype none
// ==========================================================================
// Module : sha256_axilite_regif
// AXI4-Lite register front end for the SHA-256 core: 512-bit block buffer,
// launch control and 256-bit digest capture.
// Rev    : 1.0
// ==========================================================================
module sha256_axilite_regif #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    awvalid_i,
  output logic                    awready_o,
  input  logic [ADDR_WIDTH-1:0]   awaddr_i,
  input  logic [2:0]              awprot_i,
  input  logic                    wvalid_i,
  output logic                    wready_o,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  input  logic [DATA_WIDTH/8-1:0] wstrb_i,
  output logic                    bvalid_o,
  input  logic                    bready_i,
  output logic [1:0]              bresp_o,
  input  logic                    arvalid_i,
  output logic                    arready_o,
  input  logic [ADDR_WIDTH-1:0]   araddr_i,
  input  logic [2:0]              arprot_i,
  output logic                    rvalid_o,
  input  logic                    rready_i,
  output logic [DATA_WIDTH-1:0]   rdata_o,
  output logic [1:0]              rresp_o,
  output logic                    core_start_o,
  output logic                    core_init_o,
  output logic [511:0]            core_block_o,
  input  logic                    core_ready_i,
  input  logic                    core_digest_valid_i,
  input  logic [255:0]            core_digest_i
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_RUN    = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] msg_q [16];
  logic [31:0] dig_q [8];
  logic        init_q, done_q;
  logic        aw_held_q, w_held_q, aw_oob_q;
  logic [4:0]  aw_idx_q;
  logic [31:0] w_data_q;
  logic [3:0]  w_strb_q;
  logic        bvalid_q, rvalid_q;
  logic [1:0]  bresp_q, rresp_q;
  logic [31:0] rdata_q;

  logic        busy, wr_commit, wr_err, start_req, start_go;
  logic        aw_hs, w_hs, ar_hs, ar_oob, rd_err;
  logic [4:0]  ar_idx;
  logic [31:0] rd_data;
  logic        unused_bits;

  assign unused_bits = ^{awprot_i, arprot_i, awaddr_i[1:0], araddr_i[1:0]};

  assign busy      = (state_q != ST_IDLE);
  assign awready_o = ~aw_held_q & ~bvalid_q;
  assign wready_o  = ~w_held_q & ~bvalid_q;
  assign arready_o = ~rvalid_q;
  assign aw_hs     = awvalid_i & awready_o;
  assign w_hs      = wvalid_i & wready_o;
  assign ar_hs     = arvalid_i & arready_o;
  assign wr_commit = aw_held_q & w_held_q;

  assign bvalid_o    = bvalid_q;
  assign bresp_o     = bresp_q;
  assign rvalid_o    = rvalid_q;
  assign rresp_o     = rresp_q;
  assign rdata_o     = rdata_q;
  assign core_init_o = init_q;

  for (genvar gi = 0; gi < 16; gi++) begin : g_block
    assign core_block_o[511-32*gi -: 32] = msg_q[gi];
  end

  // Address bits above the 128-byte window make the access invalid.
  assign ar_idx = araddr_i[6:2];
  assign ar_oob = |araddr_i[ADDR_WIDTH-1:7];

  assign start_req = ~aw_oob_q & (aw_idx_q == 5'd16) & w_strb_q[0] & w_data_q[0];
  assign start_go  = wr_commit & start_req & ~wr_err;

  always_comb begin
    wr_err = 1'b1;
    if (aw_oob_q) begin
      wr_err = 1'b1;
    end else if (!aw_idx_q[4]) begin
      wr_err = busy;
    end else if (aw_idx_q == 5'd16) begin
      wr_err = start_req & (busy | ~core_ready_i);
    end
  end

  always_comb begin
    rd_data = 32'd0;
    rd_err  = 1'b0;
    if (ar_oob) begin
      rd_err = 1'b1;
    end else if (!ar_idx[4]) begin
      rd_data = msg_q[ar_idx[3:0]];
    end else if (ar_idx == 5'd16) begin
      rd_data = 32'd0;
    end else if (ar_idx == 5'd17) begin
      rd_data = {30'd0, done_q, busy};
    end else if (ar_idx[4:3] == 2'b11) begin
      rd_data = dig_q[ar_idx[2:0]];
    end else begin
      rd_err = 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    core_start_o = 1'b0;
    case (state_q)
      ST_IDLE:   if (start_go) state_d = ST_LAUNCH;
      ST_LAUNCH: begin
        core_start_o = 1'b1;
        state_d      = ST_RUN;
      end
      ST_RUN:    if (core_digest_valid_i) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 16; i++) msg_q[i] <= 32'd0;
      for (int i = 0; i < 8; i++) dig_q[i] <= 32'd0;
      init_q    <= 1'b0;
      done_q    <= 1'b0;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      aw_oob_q  <= 1'b0;
      aw_idx_q  <= 5'd0;
      w_data_q  <= 32'd0;
      w_strb_q  <= 4'd0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
      rvalid_q  <= 1'b0;
      rresp_q   <= 2'b00;
      rdata_q   <= 32'd0;
    end else begin
      if (aw_hs) begin
        aw_held_q <= 1'b1;
        aw_idx_q  <= awaddr_i[6:2];
        aw_oob_q  <= |awaddr_i[ADDR_WIDTH-1:7];
      end
      if (w_hs) begin
        w_held_q <= 1'b1;
        w_data_q <= wdata_i[31:0];
        w_strb_q <= wstrb_i[3:0];
      end

      if (wr_commit) begin
        aw_held_q <= 1'b0;
        w_held_q  <= 1'b0;
        bvalid_q  <= 1'b1;
        bresp_q   <= wr_err ? 2'b10 : 2'b00;
        if (!wr_err && !aw_oob_q && !aw_idx_q[4]) begin
          for (int b = 0; b < 4; b++) begin
            if (w_strb_q[b]) msg_q[aw_idx_q[3:0]][8*b +: 8] <= w_data_q[8*b +: 8];
          end
        end
      end else if (bvalid_q && bready_i) begin
        bvalid_q <= 1'b0;
      end

      if (start_go) begin
        init_q <= w_data_q[1];
        done_q <= 1'b0;
      end

      if (state_q == ST_RUN && core_digest_valid_i) begin
        for (int i = 0; i < 8; i++) dig_q[i] <= core_digest_i[255-32*i -: 32];
        done_q <= 1'b1;
      end

      // Read data is sampled at the AR handshake, so it reflects pre-update state.
      if (ar_hs) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rd_data;
        rresp_q  <= rd_err ? 2'b10 : 2'b00;
      end else if (rvalid_q && rready_i) begin
        rvalid_q <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sha256_axilite_regif.sv
`default_nettype none
// ==========================================================================
// Module : tb_sha256_axilite_regif
// Self-checking bench with a behavioural register/core model.
// Rev    : 1.0
// ==========================================================================
module tb_sha256_axilite_regif;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
  logic         awready, wready, bvalid, arready, rvalid;
  logic [31:0]  awaddr = 0, araddr = 0, wdata = 0, rdata;
  logic [3:0]   wstrb = 0;
  logic [1:0]   bresp, rresp;
  logic [2:0]   awprot = 0, arprot = 0;
  logic         core_start, core_init;
  logic [511:0] core_block;
  logic         core_ready = 1'b1, core_digest_valid = 1'b0;
  logic [255:0] core_digest = '0;

  int checks = 0;
  int errors = 0;

  logic [31:0]  m_msg [16];
  logic [31:0]  m_dig [8];
  int           start_count = 0;
  logic         last_init = 1'b0;
  int           core_cnt = 0;
  logic         force_not_ready = 1'b0;
  logic [255:0] next_digest = '0;

  localparam logic [255:0] ABC_DIGEST =
    256'hBA7816BF_8F01CFEA_414140DE_5DAE2223_B00361A3_96177A9C_B410FF61_F20015AD;

  always #5 clk = ~clk;

  sha256_axilite_regif #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .awvalid_i(awvalid), .awready_o(awready), .awaddr_i(awaddr), .awprot_i(awprot),
    .wvalid_i(wvalid), .wready_o(wready), .wdata_i(wdata), .wstrb_i(wstrb),
    .bvalid_o(bvalid), .bready_i(bready), .bresp_o(bresp),
    .arvalid_i(arvalid), .arready_o(arready), .araddr_i(araddr), .arprot_i(arprot),
    .rvalid_o(rvalid), .rready_i(rready), .rdata_o(rdata), .rresp_o(rresp),
    .core_start_o(core_start), .core_init_o(core_init), .core_block_o(core_block),
    .core_ready_i(core_ready), .core_digest_valid_i(core_digest_valid),
    .core_digest_i(core_digest)
  );

  // Core model: 64 cycles after a start pulse, present next_digest for one cycle.
  always @(negedge clk) begin
    if (core_digest_valid) core_digest_valid = 1'b0;
    if (core_start) begin
      start_count = start_count + 1;
      last_init   = core_init;
      core_cnt    = 64;
    end else if (core_cnt > 0) begin
      core_cnt = core_cnt - 1;
      if (core_cnt == 0) begin
        core_digest       = next_digest;
        core_digest_valid = 1'b1;
      end
    end
    core_ready = (core_cnt == 0) && !force_not_ready;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] resp);
    logic awr, wr;
    bit   aw_ok, w_ok, got;
    aw_ok = 0; w_ok = 0; got = 0; resp = 2'b11;
    awaddr = addr; wdata = data; wstrb = strb; awvalid = 1; wvalid = 1;
    for (int i = 0; i < 50 && !(aw_ok && w_ok); i++) begin
      awr = awready; wr = wready;
      @(negedge clk);
      if (awvalid && awr) begin awvalid = 0; aw_ok = 1; end
      if (wvalid && wr) begin wvalid = 0; w_ok = 1; end
    end
    for (int i = 0; i < 50 && aw_ok && w_ok && !got; i++) begin
      if (bvalid) begin
        resp = bresp; got = 1; bready = 1;
        @(negedge clk);
        bready = 0;
      end else begin
        @(negedge clk);
      end
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL write_timeout addr=%h", addr);
      awvalid = 0; wvalid = 0;
    end
  endtask

  task automatic axi_read(input logic [31:0] addr, output logic [31:0] data,
                          output logic [1:0] resp);
    logic arr;
    bit   ok, got;
    ok = 0; got = 0; data = 32'hFFFF_FFFF; resp = 2'b11;
    araddr = addr; arvalid = 1;
    for (int i = 0; i < 50 && !ok; i++) begin
      arr = arready;
      @(negedge clk);
      if (arr) begin arvalid = 0; ok = 1; end
    end
    for (int i = 0; i < 50 && ok && !got; i++) begin
      if (rvalid) begin
        data = rdata; resp = rresp; got = 1; rready = 1;
        @(negedge clk);
        rready = 0;
      end else begin
        @(negedge clk);
      end
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL read_timeout addr=%h", addr);
      arvalid = 0;
    end
  endtask

  function automatic logic [511:0] model_block();
    logic [511:0] blk;
    for (int i = 0; i < 16; i++) blk[511-32*i -: 32] = m_msg[i];
    return blk;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_msg[i] = 32'd0;
    for (int i = 0; i < 8; i++) m_dig[i] = 32'd0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic [1:0]  r;
    checks++;
    if (core_start !== 1'b0 || core_init !== 1'b0 || core_block !== '0 ||
        bvalid !== 1'b0 || rvalid !== 1'b0 || awready !== 1'b1 || arready !== 1'b1) begin
      errors++;
      $display("FAIL reset_outputs start=%b init=%b bvalid=%b rvalid=%b awready=%b arready=%b want 0 0 0 0 1 1",
               core_start, core_init, bvalid, rvalid, awready, arready);
    end
    axi_read(32'h44, d, r);
    checks++;
    if (d !== 32'h0 || r !== 2'b00) begin
      errors++; $display("FAIL reset_status got %h/%b want 00000000/00", d, r);
    end
    axi_read(32'h60, d, r);
    checks++;
    if (d !== 32'h0 || r !== 2'b00) begin
      errors++; $display("FAIL reset_digest0 got %h/%b want 00000000/00", d, r);
    end
  endtask

  task automatic test_strobe();
    logic [31:0] d;
    logic [1:0]  r;
    axi_write(32'h0C, 32'hDEADBEEF, 4'h5, r);
    m_msg[3] = 32'h00AD00EF;
    checks++;
    if (r !== 2'b00) begin errors++; $display("FAIL strobe_bresp got %b want 00", r); end
    axi_read(32'h0C, d, r);
    checks++;
    if (d !== 32'h00AD00EF || r !== 2'b00) begin
      errors++; $display("FAIL strobe_readback got %h/%b want 00ad00ef/00", d, r);
    end
  endtask

  task automatic test_w_before_aw();
    logic        acc;
    int          nb;
    logic [1:0]  br;
    logic [31:0] d;
    logic [1:0]  r;
    nb = 0; br = 2'b11;
    wdata = 32'h12345678; wstrb = 4'hF; wvalid = 1; bready = 1;
    acc = wready;
    @(negedge clk);
    if (acc) wvalid = 0;
    @(negedge clk);
    awaddr = 32'h00; awvalid = 1;
    acc = awready;
    @(negedge clk);
    if (acc) awvalid = 0;
    for (int i = 0; i < 10; i++) begin
      if (bvalid) begin nb++; br = bresp; end
      @(negedge clk);
    end
    bready = 0;
    checks++;
    if (nb != 1 || br !== 2'b00 || awvalid || wvalid) begin
      errors++;
      $display("FAIL w_before_aw bcount=%0d bresp=%b awv=%b wv=%b want 1/00/0/0", nb, br, awvalid, wvalid);
    end
    awvalid = 0; wvalid = 0;
    m_msg[0] = 32'h12345678;
    axi_read(32'h00, d, r);
    checks++;
    if (d !== 32'h12345678 || r !== 2'b00) begin
      errors++; $display("FAIL w_before_aw_readback got %h/%b want 12345678/00", d, r);
    end
  endtask

  task automatic test_msg_random();
    logic [31:0] d, data;
    logic [1:0]  r;
    logic [3:0]  strb;
    int          idx, ridx;
    for (int n = 0; n < 16; n++) begin
      idx  = $urandom_range(0, 15);
      data = $urandom;
      strb = 4'($urandom_range(0, 15));
      axi_write(32'(idx * 4), data, strb, r);
      for (int b = 0; b < 4; b++) if (strb[b]) m_msg[idx][8*b +: 8] = data[8*b +: 8];
      checks++;
      if (r !== 2'b00) begin errors++; $display("FAIL rand_write_bresp idx=%0d got %b want 00", idx, r); end
      ridx = $urandom_range(0, 15);
      axi_read(32'(ridx * 4), d, r);
      checks++;
      if (d !== m_msg[ridx] || r !== 2'b00) begin
        errors++; $display("FAIL rand_read idx=%0d got %h/%b want %h/00", ridx, d, r, m_msg[ridx]);
      end
    end
    checks++;
    if (core_block !== model_block()) begin
      errors++; $display("FAIL core_block got %h want %h", core_block, model_block());
    end
  endtask

  task automatic test_invalid();
    logic [31:0] d, a;
    logic [1:0]  r;
    axi_read(32'h48, d, r);
    checks++;
    if (d !== 32'h0 || r !== 2'b10) begin errors++; $display("FAIL read_48 got %h/%b want 00000000/10", d, r); end
    for (int n = 0; n < 4; n++) begin
      a = 32'h48 + 32'($urandom_range(0, 5) * 4);
      axi_read(a, d, r);
      checks++;
      if (d !== 32'h0 || r !== 2'b10) begin errors++; $display("FAIL read_gap a=%h got %h/%b want 00000000/10", a, d, r); end
    end
    axi_read(32'h40, d, r);
    checks++;
    if (d !== 32'h0 || r !== 2'b00) begin errors++; $display("FAIL read_ctrl got %h/%b want 00000000/00", d, r); end
    axi_write(32'h80, $urandom, 4'hF, r);
    checks++;
    if (r !== 2'b10) begin errors++; $display("FAIL write_80 got %b want 10", r); end
    axi_write(32'h44, 32'h3, 4'hF, r);
    checks++;
    if (r !== 2'b10) begin errors++; $display("FAIL write_status got %b want 10", r); end
    axi_write(32'h60, 32'h1, 4'hF, r);
    checks++;
    if (r !== 2'b10) begin errors++; $display("FAIL write_digest got %b want 10", r); end
    axi_read(32'h00, d, r);
    checks++;
    if (d !== m_msg[0]) begin errors++; $display("FAIL invalid_no_effect got %h want %h", d, m_msg[0]); end
  endtask

  task automatic wait_done(input string tag);
    logic [31:0] d;
    logic [1:0]  r;
    bit          seen;
    seen = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      axi_read(32'h44, d, r);
      if (d[1]) seen = 1;
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL %s done_timeout status=%h want done", tag, d); end
  endtask

  task automatic check_digests(input string tag);
    logic [31:0] d;
    logic [1:0]  r;
    for (int i = 0; i < 8; i++) begin
      axi_read(32'h60 + 32'(i * 4), d, r);
      checks++;
      if (d !== m_dig[i] || r !== 2'b00) begin
        errors++; $display("FAIL %s digest%0d got %h/%b want %h/00", tag, i, d, r, m_dig[i]);
      end
    end
  endtask

  task automatic test_abc_hash();
    logic [31:0] d;
    logic [1:0]  r;
    int          s0;
    for (int i = 0; i < 16; i++) begin
      m_msg[i] = (i == 0) ? 32'h61626380 : (i == 15) ? 32'h00000018 : 32'h0;
      axi_write(32'(i * 4), m_msg[i], 4'hF, r);
    end
    checks++;
    if (core_block !== model_block()) begin errors++; $display("FAIL abc_block got %h want %h", core_block, model_block()); end
    next_digest = ABC_DIGEST;
    s0 = start_count;
    axi_write(32'h40, 32'h3, 4'hF, r);
    checks++;
    if (r !== 2'b00) begin errors++; $display("FAIL abc_start_bresp got %b want 00", r); end
    axi_read(32'h44, d, r);
    checks++;
    if (d !== 32'h1) begin errors++; $display("FAIL abc_busy got %h want 00000001", d); end
    axi_write(32'h00, $urandom, 4'hF, r);
    checks++;
    if (r !== 2'b10) begin errors++; $display("FAIL busy_msg_write got %b want 10", r); end
    axi_read(32'h00, d, r);
    checks++;
    if (d !== 32'h61626380 || r !== 2'b00) begin errors++; $display("FAIL busy_msg_read got %h/%b want 61626380/00", d, r); end
    axi_write(32'h40, 32'h1, 4'hF, r);
    checks++;
    if (r !== 2'b10) begin errors++; $display("FAIL busy_start got %b want 10", r); end
    wait_done("abc");
    for (int i = 0; i < 8; i++) m_dig[i] = ABC_DIGEST[255-32*i -: 32];
    checks++;
    if (start_count != s0 + 1 || last_init !== 1'b1) begin
      errors++; $display("FAIL abc_start_pulses got %0d init=%b want 1 init=1", start_count - s0, last_init);
    end
    axi_read(32'h44, d, r);
    checks++;
    if (d !== 32'h2) begin errors++; $display("FAIL abc_status got %h want 00000002", d); end
    check_digests("abc");
  endtask

  task automatic test_chain();
    logic [31:0] d;
    logic [1:0]  r;
    logic [255:0] dg;
    int          s0;
    s0 = start_count;
    axi_write(32'h40, 32'h3, 4'h2, r);
    repeat (4) @(negedge clk);
    checks++;
    if (r !== 2'b00 || start_count != s0) begin
      errors++; $display("FAIL ctrl_nostrb bresp=%b starts=%0d want 00/0", r, start_count - s0);
    end
    m_msg[1] = $urandom;
    axi_write(32'h04, m_msg[1], 4'hF, r);
    for (int i = 0; i < 8; i++) dg[255-32*i -: 32] = $urandom;
    next_digest = dg;
    axi_write(32'h40, 32'h1, 4'h1, r);
    axi_read(32'h44, d, r);
    checks++;
    if (d !== 32'h1) begin errors++; $display("FAIL chain_status_run got %h want 00000001", d); end
    wait_done("chain");
    for (int i = 0; i < 8; i++) m_dig[i] = dg[255-32*i -: 32];
    checks++;
    if (start_count != s0 + 1 || last_init !== 1'b0) begin
      errors++; $display("FAIL chain_start got %0d init=%b want 1 init=0", start_count - s0, last_init);
    end
    check_digests("chain");
  endtask

  task automatic test_not_ready();
    logic [1:0] r;
    int         s0;
    force_not_ready = 1'b1;
    @(negedge clk);
    s0 = start_count;
    axi_write(32'h40, 32'h1, 4'hF, r);
    repeat (4) @(negedge clk);
    checks++;
    if (r !== 2'b10 || start_count != s0) begin
      errors++; $display("FAIL not_ready_start bresp=%b starts=%0d want 10/0", r, start_count - s0);
    end
    force_not_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_bresp_hold();
    logic [31:0] data, d;
    logic [1:0]  r;
    bit          seen, bad;
    data = $urandom;
    awaddr = 32'h14; wdata = data; wstrb = 4'hF; awvalid = 1; wvalid = 1;
    seen = 0; bad = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (awvalid && !awready) awvalid = 0;
      if (wvalid && !wready) wvalid = 0;
      if (bvalid) seen = 1;
    end
    awvalid = 1; wvalid = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bvalid !== 1'b1 || awready !== 1'b0 || wready !== 1'b0) bad = 1;
    end
    awvalid = 0; wvalid = 0;
    checks++;
    if (!seen || bad) begin
      errors++; $display("FAIL bresp_hold seen=%b bvalid=%b awready=%b wready=%b want 1 1 0 0", seen, bvalid, awready, wready);
    end
    checks++;
    if (bresp !== 2'b00) begin errors++; $display("FAIL bresp_hold_resp got %b want 00", bresp); end
    bready = 1;
    @(negedge clk);
    bready = 0;
    m_msg[5] = data;
    axi_read(32'h14, d, r);
    checks++;
    if (d !== data) begin errors++; $display("FAIL bresp_hold_readback got %h want %h", d, data); end
  endtask

  task automatic test_reset_mid_run();
    logic [31:0] d;
    logic [1:0]  r;
    axi_write(32'h40, 32'h1, 4'hF, r);
    repeat (10) @(negedge clk);
    arvalid = 1; araddr = 32'h44;
    @(negedge clk);
    rst_n = 0;
    arvalid = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    model_reset();
    checks++;
    if (bvalid !== 1'b0 || rvalid !== 1'b0 || core_start !== 1'b0) begin
      errors++; $display("FAIL midrun_reset_outputs bvalid=%b rvalid=%b start=%b want 0 0 0", bvalid, rvalid, core_start);
    end
    axi_read(32'h44, d, r);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL midrun_status got %h want 00000000", d); end
    repeat (70) @(negedge clk);
    axi_read(32'h44, d, r);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL idle_digest_ignored status got %h want 00000000", d); end
    axi_read(32'h60, d, r);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL idle_digest_ignored d0 got %h want 00000000", d); end
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    test_reset();
    test_strobe();
    test_w_before_aw();
    test_msg_random();
    test_invalid();
    test_abc_hash();
    test_chain();
    test_not_ready();
    test_bresp_hold();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
